mux_stage_n: RTL and testbench
==============================

# mux_stage_n

Parametrised N-input, registered select stage for the MIPS datapath. It picks one of NUM_IN operand channels per transfer and holds the result in a two-entry skid buffer with valid/ready handshakes, so operand selection can sit on a pipeline boundary without a combinational ready path. It generalises the 5-bit 2:1 select used for register-destination choice to any width and channel count. It adds flow control, flush and out-of-range select detection.

## Interface
- WIDTH, 32, data width of each channel and of Dout
- NUM_IN, 4, number of input channels (2..16)
- SEL_W, $clog2(NUM_IN), select width (derived; not overridden)

- Clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Din  in  NUM_IN*WIDTH  packed channels; channel k = Din[k*WIDTH +: WIDTH]
- Sel  in  SEL_W  channel select, sampled with the input transfer
- InValid  in  1  upstream has a word
- InReady  out  1  stage can accept a word
- Flush  in  1  discard all held words
- Dout  out  WIDTH  selected word at head of buffer
- OutErr  out  1  head word was captured with Sel >= NUM_IN
- OutValid  out  1  Dout/OutErr valid
- OutReady  in  1  downstream accepts the word
- Occupancy  out  2  number of held words (0..2)

## Operation
- Input transfer: InValid && InReady at a rising edge. Output transfer: OutValid && OutReady at a rising edge.
- Captured word: Din channel Sel if Sel < NUM_IN. Otherwise the word is all zeros and its err bit is 1. The err bit travels with the word.
- Storage: a main register (drives Dout/OutErr/OutValid) and a skid register. States: EMPTY, ONE, TWO. Occupancy = 0/1/2.
- EMPTY: input → ONE (word to main).
- ONE:
  - input only → TWO (word to skid).
  - output only → EMPTY.
  - input and output → ONE (new word replaces main).
- TWO: InReady = 0. Output → ONE (skid moves to main). Otherwise hold.
- InReady = (state != TWO). It depends on registered state only, with no combinational path from OutReady.
- Flush: the next state is EMPTY whatever the other inputs. A word offered in the same cycle is discarded, even if InValid && InReady. An output transfer in the same cycle still counts downstream.
- Reset: state EMPTY. Dout = 0, OutErr = 0, OutValid = 0, Occupancy = 0, InReady = 1. Reset overrides Flush and both handshakes.
- Words leave in acceptance order. No word is duplicated or dropped except by Flush or Reset.
- While OutValid && !OutReady, Dout and OutErr stay stable.

## Timing
- Latency: a word accepted at edge n is on Dout with OutValid = 1 after edge n (visible in cycle n+1).
- Throughput: 1 word per cycle when OutReady is held at 1.
- After one stall cycle (TWO), InReady returns to 1 in the cycle after the first output transfer.
- Sel and Din are sampled only at an input-transfer edge. Changes at other times have no effect.
- Reset or Flush asserted mid-stream: outputs show the cleared values from the cycle after that edge.

## Structure
- Shared package mips_pkg holds:
  - the state encoding constants (ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2);
  - the default WIDTH.
- One sub-module, mux_n_comb, is natural. It is the purely combinational NUM_IN:1 select with zero-fill and an err flag on out-of-range Sel, and it is reusable elsewhere in the datapath.
- The skid/state logic stays in mux_stage_n.

## Test plan
- Basic select: NUM_IN = 4, WIDTH = 32, channels = 0x11, 0x22, 0x33, 0x44; Sel = 2; one transfer with OutReady = 1 → next cycle Dout = 0x33, OutValid = 1, OutErr = 0, Occupancy = 1.
- Out-of-range select: NUM_IN = 3, Sel = 3, one transfer → Dout = 0, OutErr = 1. The following word with Sel = 0 has OutErr = 0.
- Backpressure:
  - Setup: OutReady = 0, three words (Sel = 0, 1, 2) offered back-to-back.
  - While blocked: the first two are accepted, InReady = 0 on the third cycle, Occupancy = 2, and Dout holds channel 0 stable.
  - After release (OutReady = 1): outputs appear in order 0, 1, 2 with none lost.
- Streaming: InValid = OutReady = 1 for 16 cycles, Sel cycling 0..3 → 16 outputs in order, Occupancy stays 1, InReady never drops.
- Flush: in TWO, assert Flush together with a valid input → next cycle OutValid = 0, Occupancy = 0, InReady = 1. The flushed input never appears.
- Reset mid-operation: in TWO, assert Reset for one cycle with InValid = 1 → Dout = 0, OutErr = 0, OutValid = 0, Occupancy = 0, InReady = 1. The next accepted word appears one cycle after its acceptance edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared datapath definitions: skid stage state encoding and default widths.
package mips_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } stage_state_e;

endpackage

// File: rtl/mux_stage_n_if.sv
// Handshake/data bundle between an operand source/sink and mux_stage_n.
interface mux_stage_n_if
  import mips_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
);
  logic [NUM_IN*WIDTH-1:0] Din;
  logic [SEL_W-1:0]        Sel;
  logic                    InValid;
  logic                    InReady;
  logic                    Flush;
  logic [WIDTH-1:0]        Dout;
  logic                    OutErr;
  logic                    OutValid;
  logic                    OutReady;
  logic [1:0]              Occupancy;

  modport master (
    output Din, Sel, InValid, Flush, OutReady,
    input  InReady, Dout, OutErr, OutValid, Occupancy
  );

  modport slave (
    input  Din, Sel, InValid, Flush, OutReady,
    output InReady, Dout, OutErr, OutValid, Occupancy
  );
endinterface

// File: rtl/mux_n_comb.sv
// Combinational NUM_IN:1 select; out-of-range select yields zero data and err.
module mux_n_comb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] din_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic                    err_o
);

  // Scan all channels; a non-matching select leaves the zero/err defaults.
  always_comb begin
    dout_o = '0;
    err_o  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        dout_o = din_i[k*WIDTH +: WIDTH];
        err_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_stage_n.sv
// Registered N:1 operand select with a two-entry skid buffer. InReady comes
// from registered state only, so no combinational path runs from OutReady.
module mux_stage_n
  import mips_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = 4
) (
  input logic         Clk,
  input logic         Reset,
  mux_stage_n_if.slave bus
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic             in_ready, out_valid, in_xfer, out_xfer;

  mux_n_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_sel (
    .din_i  (bus.Din),
    .sel_i  (bus.Sel),
    .dout_o (cap_data),
    .err_o  (cap_err)
  );

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = bus.InValid && in_ready;
  assign out_xfer  = out_valid && bus.OutReady;

  assign bus.InReady   = in_ready;
  assign bus.OutValid  = out_valid;
  assign bus.Dout      = main_q;
  assign bus.OutErr    = main_err_q;
  assign bus.Occupancy = state_q;

  // Next state and buffer contents from the two handshakes; Flush wins.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_err_d = main_err_q;
    skid_d     = skid_q;
    skid_err_d = skid_err_q;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          main_d     = cap_data;
          main_err_d = cap_err;
          state_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (in_xfer) begin
          if (out_xfer) begin
            main_d     = cap_data;
            main_err_d = cap_err;
          end else begin
            skid_d     = cap_data;
            skid_err_d = cap_err;
            state_d    = S_TWO;
          end
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          main_d     = skid_q;
          main_err_d = skid_err_q;
          state_d    = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush also clears the head word so Dout/OutErr read zero afterwards.
    if (bus.Flush) begin
      state_d    = S_EMPTY;
      main_d     = '0;
      main_err_d = 1'b0;
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      main_err_q <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_err_q <= main_err_d;
      skid_q     <= skid_d;
      skid_err_q <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_mux_stage_n.sv
// Bench for mux_stage_n: a 4-input and a 3-input instance share one stimulus
// stream; a queue model predicts both every cycle, plus directed literal checks.
module tb_mux_stage_n;

  logic        clk = 1'b0;
  logic        rst, flush, inv, outr;
  logic [1:0]  sel;
  logic [31:0] ch [4];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] d4;
    logic [31:0] d3;
    logic        e3;
  } item_t;
  item_t q[$];
  bit    cleared = 1'b1;

  mux_stage_n_if #(.WIDTH(32), .NUM_IN(4)) if4 ();
  mux_stage_n_if #(.WIDTH(32), .NUM_IN(3)) if3 ();

  mux_stage_n #(.WIDTH(32), .NUM_IN(4)) dut4 (.Clk(clk), .Reset(rst), .bus(if4));
  mux_stage_n #(.WIDTH(32), .NUM_IN(3)) dut3 (.Clk(clk), .Reset(rst), .bus(if3));

  always #5 clk = ~clk;

  assign if4.Din      = {ch[3], ch[2], ch[1], ch[0]};
  assign if3.Din      = {ch[2], ch[1], ch[0]};
  assign if4.Sel      = sel;
  assign if3.Sel      = sel;
  assign if4.InValid  = inv;
  assign if3.InValid  = inv;
  assign if4.Flush    = flush;
  assign if3.Flush    = flush;
  assign if4.OutReady = outr;
  assign if3.OutReady = outr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two words, updated from the inputs
  // present at each rising edge, then compared against both DUTs.
  always @(posedge clk) begin
    item_t it;
    bit    can_in, has_out;
    can_in  = (q.size() < 2);
    has_out = (q.size() > 0);
    if (rst) begin
      q.delete();
      cleared = 1'b1;
    end else begin
      if (has_out && outr) void'(q.pop_front());
      if (flush) begin
        q.delete();
        cleared = 1'b1;
      end else if (inv && can_in) begin
        it.d4 = ch[sel];
        it.d3 = (sel < 2'd3) ? ch[sel] : 32'd0;
        it.e3 = (sel == 2'd3);
        q.push_back(it);
        cleared = 1'b0;
      end
    end
    #1;
    chk("occ4", 64'(if4.Occupancy), 64'(q.size()));
    chk("occ3", 64'(if3.Occupancy), 64'(q.size()));
    chk("ovalid4", 64'(if4.OutValid), 64'(q.size() > 0));
    chk("ovalid3", 64'(if3.OutValid), 64'(q.size() > 0));
    chk("iready4", 64'(if4.InReady), 64'(q.size() < 2));
    chk("iready3", 64'(if3.InReady), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("dout4", 64'(if4.Dout), 64'(q[0].d4));
      chk("err4", 64'(if4.OutErr), 64'd0);
      chk("dout3", 64'(if3.Dout), 64'(q[0].d3));
      chk("err3", 64'(if3.OutErr), 64'(q[0].e3));
    end else if (cleared) begin
      chk("dout4_clr", 64'(if4.Dout), 64'd0);
      chk("dout3_clr", 64'(if3.Dout), 64'd0);
      chk("err3_clr", 64'(if3.OutErr), 64'd0);
    end
  end

  // One clock of stimulus; returns at the falling edge after the rising edge.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [1:0] s, input logic ordy);
    rst = r; flush = f; inv = iv; sel = s; outr = ordy;
    @(negedge clk);
  endtask

  initial begin
    ch[0] = 32'h11; ch[1] = 32'h22; ch[2] = 32'h33; ch[3] = 32'h44;
    rst = 1'b1; flush = 1'b0; inv = 1'b0; sel = 2'd0; outr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", 64'(if4.Dout), 64'd0);
    chk("rst_ovalid", 64'(if4.OutValid), 64'd0);
    chk("rst_occ", 64'(if4.Occupancy), 64'd0);
    chk("rst_iready", 64'(if4.InReady), 64'd1);

    // Basic select and out-of-range select on the 3-input instance.
    cyc(0, 0, 1, 2'd2, 1);
    chk("basic_dout", 64'(if4.Dout), 64'h33);
    chk("basic_ovalid", 64'(if4.OutValid), 64'd1);
    chk("basic_err", 64'(if4.OutErr), 64'd0);
    chk("basic_occ", 64'(if4.Occupancy), 64'd1);
    cyc(0, 0, 1, 2'd3, 1);
    chk("oor_dout3", 64'(if3.Dout), 64'd0);
    chk("oor_err3", 64'(if3.OutErr), 64'd1);
    chk("oor_dout4", 64'(if4.Dout), 64'h44);
    cyc(0, 0, 1, 2'd0, 1);
    chk("after_oor_err3", 64'(if3.OutErr), 64'd0);
    chk("after_oor_dout3", 64'(if3.Dout), 64'h11);
    cyc(0, 0, 0, 2'd0, 1);
    chk("drain_ovalid", 64'(if4.OutValid), 64'd0);

    // Backpressure: third word stalls, then everything drains in order.
    cyc(0, 0, 1, 2'd0, 0);
    chk("bp_occ1", 64'(if4.Occupancy), 64'd1);
    cyc(0, 0, 1, 2'd1, 0);
    chk("bp_occ2", 64'(if4.Occupancy), 64'd2);
    chk("bp_iready", 64'(if4.InReady), 64'd0);
    cyc(0, 0, 1, 2'd2, 0);
    chk("bp_hold_dout", 64'(if4.Dout), 64'h11);
    chk("bp_hold_occ", 64'(if4.Occupancy), 64'd2);
    cyc(0, 0, 1, 2'd2, 1);
    chk("bp_rel1", 64'(if4.Dout), 64'h22);
    chk("bp_rel1_iready", 64'(if4.InReady), 64'd1);
    cyc(0, 0, 1, 2'd2, 1);
    chk("bp_rel2", 64'(if4.Dout), 64'h33);
    cyc(0, 0, 0, 2'd0, 1);
    chk("bp_empty", 64'(if4.OutValid), 64'd0);

    // Streaming at one word per cycle.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 2'(i % 4), 1);
      chk("stream_dout", 64'(if4.Dout), 64'(ch[i % 4]));
      chk("stream_occ", 64'(if4.Occupancy), 64'd1);
      chk("stream_iready", 64'(if4.InReady), 64'd1);
    end
    cyc(0, 0, 0, 2'd0, 1);

    // Flush in TWO with a word offered.
    cyc(0, 0, 1, 2'd1, 0);
    cyc(0, 0, 1, 2'd2, 0);
    cyc(0, 1, 1, 2'd3, 0);
    chk("flush_ovalid", 64'(if4.OutValid), 64'd0);
    chk("flush_occ", 64'(if4.Occupancy), 64'd0);
    chk("flush_iready", 64'(if4.InReady), 64'd1);
    cyc(0, 0, 0, 2'd0, 1);
    chk("flush_gone", 64'(if4.OutValid), 64'd0);

    // Reset in TWO with a word offered.
    cyc(0, 0, 1, 2'd1, 0);
    cyc(0, 0, 1, 2'd2, 0);
    cyc(1, 0, 1, 2'd3, 0);
    chk("mrst_dout", 64'(if4.Dout), 64'd0);
    chk("mrst_err3", 64'(if3.OutErr), 64'd0);
    chk("mrst_ovalid", 64'(if4.OutValid), 64'd0);
    chk("mrst_occ", 64'(if4.Occupancy), 64'd0);
    chk("mrst_iready", 64'(if4.InReady), 64'd1);
    cyc(0, 0, 1, 2'd1, 0);
    chk("mrst_next", 64'(if4.Dout), 64'h22);
    chk("mrst_next_v", 64'(if4.OutValid), 64'd1);
    cyc(0, 0, 0, 2'd0, 1);

    // Randomised traffic; the model process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 70), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 60));
    end
    cyc(0, 0, 0, 2'd0, 1);
    cyc(0, 0, 0, 2'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
